// File: rtl/fir_mac_addr_gen.sv
// ---------------------------------------------------------------------------
// FirMacAddrGen (module fir_mac_addr_gen)
//
// Two-level address sequencer for the FIR datapath. For a configured sample
// count N and tap count T it walks every (sample, coefficient) pair of a full
// linear convolution. Output index k runs over 0..N+T-2. For each k, the tap
// index j runs from jmin(k) to jmax(k). One pair is emitted per valid/ready
// handshake. The pair is tagged with first/last markers so the MAC can clear
// and write back its accumulator.
//
// Ports:
//   clk_b, rst_n     clock, asynchronous active-low reset
//   cfg_load         latch cfg_n_samples / cfg_n_taps (ignored while busy)
//   cfg_n_samples    sample count N, 1..2^ADDR_W
//   cfg_n_taps       tap count T, 1..2^COEF_W
//   start            begin a run (ignored while busy or cfg_err)
//   abort            synchronous return to IDLE, highest priority
//   out_valid/ready  handshake for the address pair
//   a_sample         sample RAM address k-j
//   a_coef           coefficient RAM address j
//   out_k            output sample index k
//   first, last      first / last MAC of output k
//   busy             run in progress
//   done             one-cycle pulse after the final pair is accepted
//   cfg_err          latched config has N=0 or T=0
// ---------------------------------------------------------------------------
module fir_mac_addr_gen #(
   parameter int ADDR_W = 13,
   parameter int COEF_W = 6
) (
   input  logic              clk_b,
   input  logic              rst_n,
   input  logic              cfg_load,
   input  logic [ADDR_W:0]   cfg_n_samples,
   input  logic [COEF_W:0]   cfg_n_taps,
   input  logic              start,
   input  logic              abort,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] a_sample,
   output logic [COEF_W-1:0] a_coef,
   output logic [ADDR_W:0]   out_k,
   output logic              first,
   output logic              last,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   // Wide enough that k-N+1 and N+T-2 never wrap.
   localparam int W = ADDR_W + 2;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t              state;
   logic [ADDR_W:0]     n_reg;
   logic [COEF_W:0]     t_reg;

   logic [W-1:0] n_w, t_w, k_w, j_w;
   logic [W-1:0] k_end, jmax_cur;
   logic [W-1:0] nk, nj, nj_min, nj_max, n_samp;
   logic         run_end;
   logic         load_zero;
   logic         err_eff;
   logic         handshake;

   // Next-pair arithmetic. The current pair lives in the output registers
   // (out_k, a_coef), so this block works out the pair that follows it.
   // Either j steps up inside the current k, or k steps up and j restarts at
   // jmin(k+1). The first/last flags and the sample address of that pair are
   // also computed here, so every output can be registered directly.
   always_comb begin
      n_w      = W'(n_reg);
      t_w      = W'(t_reg);
      k_w      = W'(out_k);
      j_w      = W'(a_coef);
      k_end    = n_w + t_w - W'(2);
      jmax_cur = (k_w < t_w - W'(1)) ? k_w : t_w - W'(1);
      run_end  = (j_w >= jmax_cur) && (k_w >= k_end);
      nk       = k_w;
      nj       = j_w + W'(1);
      if (j_w >= jmax_cur) begin
         nk = k_w + W'(1);
         nj = (nk >= n_w) ? nk - n_w + W'(1) : '0;
      end
      nj_min   = (nk >= n_w) ? nk - n_w + W'(1) : '0;
      nj_max   = (nk < t_w - W'(1)) ? nk : t_w - W'(1);
      n_samp   = nk - nj;
   end

   // A cfg_load in the same cycle as start takes effect first, so start
   // looks at the error flag that the new configuration would produce.
   always_comb begin
      load_zero = (cfg_n_samples == '0) || (cfg_n_taps == '0);
      err_eff   = cfg_load ? load_zero : cfg_err;
      handshake = out_valid && out_ready;
   end

   // Control FSM and all registered outputs. In IDLE, the block accepts a
   // configuration and a start. In RUN, it advances one pair per handshake.
   // Leaving RUN clears the pair outputs, so an idle block always shows zeros.
   // Abort is checked before anything else in RUN, so it wins over a
   // handshake in the same cycle. It also blocks a start in IDLE.
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         n_reg     <= '0;
         t_reg     <= '0;
         cfg_err   <= 1'b0;
         out_valid <= 1'b0;
         a_sample  <= '0;
         a_coef    <= '0;
         out_k     <= '0;
         first     <= 1'b0;
         last      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_load) begin
                  n_reg   <= cfg_n_samples;
                  t_reg   <= cfg_n_taps;
                  cfg_err <= load_zero;
               end
               if (start && !abort && !err_eff) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  out_valid <= 1'b1;
                  out_k     <= '0;
                  a_coef    <= '0;
                  a_sample  <= '0;
                  first     <= 1'b1;
                  last      <= 1'b1;
               end
            end
            RUN: begin
               if (abort || (handshake && run_end)) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  out_k     <= '0;
                  a_coef    <= '0;
                  a_sample  <= '0;
                  first     <= 1'b0;
                  last      <= 1'b0;
                  done      <= !abort;
               end else if (handshake) begin
                  out_k    <= nk[ADDR_W:0];
                  a_coef   <= nj[COEF_W-1:0];
                  a_sample <= n_samp[ADDR_W-1:0];
                  first    <= (nj == nj_min);
                  last     <= (nj == nj_max);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_addr_gen.sv
// ---------------------------------------------------------------------------
// TbFirMacAddrGen (module tb_fir_mac_addr_gen)
//
// Self-checking bench for fir_mac_addr_gen. Smaller address widths keep the
// full-size run short. When a run is started, the expected pair stream is
// built from the convolution definition and pushed into a scoreboard queue.
// The queue front is compared against the DUT every cycle. It is popped on
// each handshake, so stalls also prove the outputs held.
// ---------------------------------------------------------------------------
module tb_fir_mac_addr_gen;

   localparam int AW = 8;
   localparam int CW = 4;

   logic          clk_b = 1'b0;
   logic          rst_n;
   logic          cfg_load;
   logic [AW:0]   cfg_n_samples;
   logic [CW:0]   cfg_n_taps;
   logic          start;
   logic          abort;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] a_sample;
   logic [CW-1:0] a_coef;
   logic [AW:0]   out_k;
   logic          first;
   logic          last;
   logic          busy;
   logic          done;
   logic          cfg_err;

   fir_mac_addr_gen #(.ADDR_W(AW), .COEF_W(CW)) dut (
      .clk_b         (clk_b),
      .rst_n         (rst_n),
      .cfg_load      (cfg_load),
      .cfg_n_samples (cfg_n_samples),
      .cfg_n_taps    (cfg_n_taps),
      .start         (start),
      .abort         (abort),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .a_sample      (a_sample),
      .a_coef        (a_coef),
      .out_k         (out_k),
      .first         (first),
      .last          (last),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err)
   );

   // Free-running clock.
   always #5 clk_b = ~clk_b;

   typedef struct {
      int n;
      int t;
      int ready_pct;
      int exp_pairs;
      int exp_lasts;
      int exp_last_sample;
   } vec_t;

   vec_t        vecs[5];
   logic [63:0] sb[$];
   int          cap[$];
   int          order43[12];
   int          checks   = 0;
   int          failures = 0;
   int          runAccepted;
   int          runCycles;
   int          runLasts;
   int          runLastSample;

   function automatic logic [63:0] packPair(input logic v, input logic [AW:0] k,
                                            input logic [AW-1:0] s, input logic [CW-1:0] c,
                                            input logic f, input logic l);
      return {40'd0, v, k, s, c, f, l};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference stream straight from the convolution definition.
   task automatic pushModel(input int n, input int t);
      for (int k = 0; k <= n + t - 2; k++) begin
         int jmin;
         int jmax;
         jmin = (k >= n) ? k - n + 1 : 0;
         jmax = (k < t - 1) ? k : t - 1;
         for (int j = jmin; j <= jmax; j++)
            sb.push_back(packPair(1'b1, (AW+1)'(k), AW'(k - j), CW'(j), j == jmin, j == jmax));
      end
   endtask

   // Consume pairs until the scoreboard empties or max_accept handshakes are
   // done. When inject_at >= 0, a cfg_load(N=7)+start pulse is driven mid-run.
   task automatic runPairs(input int max_accept, input int ready_pct, input int inject_at);
      int budget;
      bit injected;
      budget        = sb.size() * 4 + 50;
      injected      = 1'b0;
      runAccepted   = 0;
      runCycles     = 0;
      runLasts      = 0;
      runLastSample = -1;
      cap.delete();
      while (sb.size() > 0 && runAccepted < max_accept && runCycles < budget) begin
         @(negedge clk_b);
         runCycles++;
         cfg_load = 1'b0;
         start    = 1'b0;
         if (!injected && runAccepted == inject_at) begin
            injected      = 1'b1;
            cfg_load      = 1'b1;
            cfg_n_samples = (AW+1)'(7);
            start         = 1'b1;
         end
         out_ready = ($urandom_range(99) < ready_pct);
         checkOutput("pair", packPair(out_valid, out_k, a_sample, a_coef, first, last), sb[0]);
         if (out_valid && out_ready) begin
            void'(sb.pop_front());
            runAccepted++;
            if (last) runLasts++;
            runLastSample = int'(a_sample);
            cap.push_back(int'(a_coef));
         end
      end
      if (sb.size() > 0 && runAccepted < max_accept) begin
         checks++;
         failures++;
         $display("[TB] FAIL timeout: %0d pairs still expected after %0d cycles", sb.size(), runCycles);
      end
   endtask

   // Load a config and start in the same cycle, run to completion, then
   // check the done pulse timing.
   task automatic applyStimulus(input int n, input int t, input int pct, input int inject_at);
      @(negedge clk_b);
      out_ready     = 1'b0;
      cfg_load      = 1'b1;
      cfg_n_samples = (AW+1)'(n);
      cfg_n_taps    = (CW+1)'(t);
      start         = 1'b1;
      sb.delete();
      pushModel(n, t);
      runPairs(1 << 30, pct, inject_at);
      @(negedge clk_b);
      cfg_load = 1'b0;
      start    = 1'b0;
      checkOutput("done_pulse", 64'({done, out_valid, busy}), 64'b100);
      @(negedge clk_b);
      checkOutput("done_clear", 64'(done), 64'd0);
      out_ready = 1'b0;
   endtask

   // Hard stop in case something deadlocks outside a bounded wait.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: reset state, table vectors, then the hand-written cases.
   initial begin
      rst_n         = 1'b0;
      cfg_load      = 1'b0;
      cfg_n_samples = '0;
      cfg_n_taps    = '0;
      start         = 1'b0;
      abort         = 1'b0;
      out_ready     = 1'b0;

      vecs[0] = '{4,   3,  100, 12,   6,   3};
      vecs[1] = '{1,   1,  100, 1,    1,   0};
      vecs[2] = '{256, 16, 100, 4096, 271, 255};
      vecs[3] = '{3,   5,  50,  15,   7,   2};
      vecs[4] = '{5,   2,  70,  10,   6,   4};
      order43 = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 1, 2, 2};

      #12;
      checkOutput("reset_state", {37'd0, out_valid, busy, done, cfg_err, out_k, a_sample,
                                  a_coef, first, last}, 64'd0);
      @(negedge clk_b);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].n, vecs[i].t, vecs[i].ready_pct, -1);
         checkOutput("pair_count", 64'(runAccepted), 64'(vecs[i].exp_pairs));
         checkOutput("last_count", 64'(runLasts), 64'(vecs[i].exp_lasts));
         checkOutput("last_sample", 64'(runLastSample), 64'(vecs[i].exp_last_sample));
         if (vecs[i].ready_pct == 100)
            checkOutput("throughput", 64'(runCycles), 64'(vecs[i].exp_pairs));
         if (vecs[i].n == 4 && vecs[i].t == 3) begin
            checkOutput("order_len", 64'(cap.size()), 64'd12);
            for (int m = 0; m < 12 && m < cap.size(); m++)
               checkOutput("order_j", 64'(cap[m]), 64'(order43[m]));
         end
      end

      // Zero sample count latches cfg_err and blocks start.
      @(negedge clk_b);
      cfg_load      = 1'b1;
      cfg_n_samples = '0;
      cfg_n_taps    = (CW+1)'(3);
      @(negedge clk_b);
      cfg_load = 1'b0;
      checkOutput("cfg_err_set", 64'(cfg_err), 64'd1);
      start = 1'b1;
      @(negedge clk_b);
      start = 1'b0;
      checkOutput("start_ignored", 64'({busy, out_valid}), 64'd0);
      applyStimulus(2, 2, 100, -1);
      checkOutput("cfg_err_clear", 64'(cfg_err), 64'd0);
      checkOutput("recover_count", 64'(runAccepted), 64'd4);

      // Abort after the 5th handshake, with a handshake in the abort cycle.
      @(negedge clk_b);
      cfg_load      = 1'b1;
      cfg_n_samples = (AW+1)'(4);
      cfg_n_taps    = (CW+1)'(3);
      start         = 1'b1;
      sb.delete();
      pushModel(4, 3);
      runPairs(5, 100, -1);
      checkOutput("abort_hs5", 64'(runAccepted), 64'd5);
      @(negedge clk_b);
      abort     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk_b);
      abort = 1'b0;
      checkOutput("abort_idle", 64'({done, busy, out_valid}), 64'd0);
      @(negedge clk_b);
      checkOutput("abort_no_done", 64'(done), 64'd0);
      out_ready = 1'b0;
      applyStimulus(4, 3, 100, -1);
      checkOutput("restart_count", 64'(runAccepted), 64'd12);

      // cfg_load(N=7) plus start mid-run must be ignored.
      applyStimulus(4, 3, 100, 3);
      checkOutput("inject_count", 64'(runAccepted), 64'd12);
      checkOutput("inject_lasts", 64'(runLasts), 64'd6);

      // Asynchronous reset in the middle of a run.
      @(negedge clk_b);
      cfg_load      = 1'b1;
      cfg_n_samples = (AW+1)'(4);
      cfg_n_taps    = (CW+1)'(3);
      start         = 1'b1;
      @(negedge clk_b);
      cfg_load  = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk_b);
      checkOutput("busy_before_reset", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", {37'd0, out_valid, busy, done, cfg_err, out_k, a_sample,
                                  a_coef, first, last}, 64'd0);
      @(negedge clk_b);
      rst_n     = 1'b1;
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_mac_addr_gen.md
# fir_mac_addr_gen

Parametrised address sequencer for the FIR datapath. It replaces the single sample counter with a two-level generator that walks every (sample, coefficient) pair of a full linear convolution. It emits one MAC address pair per handshake, with first/last markers per output sample. It sits between the control FSM and the sample/coefficient RAMs.

## Interface
Parameters:
- ADDR_W, 13, sample RAM address width
- COEF_W, 6, coefficient RAM address width; must satisfy COEF_W <= ADDR_W

Ports:
- clk_b  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_load  in  1  latch cfg_n_samples and cfg_n_taps; ignored while busy
- cfg_n_samples  in  ADDR_W+1  sample count N, legal range 1..2^ADDR_W
- cfg_n_taps  in  COEF_W+1  tap count T, legal range 1..2^COEF_W
- start  in  1  begin a run; ignored while busy or cfg_err
- abort  in  1  synchronous return to IDLE; highest priority
- out_valid  out  1  address pair valid
- out_ready  in  1  consumer accepts the pair
- a_sample  out  ADDR_W  sample address, k-j
- a_coef  out  COEF_W  coefficient address, j
- out_k  out  ADDR_W+1  output sample index k
- first  out  1  pair is the first MAC of output k; consumer clears its accumulator
- last  out  1  pair is the last MAC of output k; consumer writes its result
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the final pair is accepted
- cfg_err  out  1  latched config has N=0 or T=0; sticky until the next cfg_load

## Operation
- States are IDLE and RUN. Reset puts the block in IDLE. Reset values:
  - every output is 0
  - the internal N and T registers are 0
  - cfg_err is 0
- cfg_load in IDLE:
  - N <= cfg_n_samples and T <= cfg_n_taps
  - cfg_err <= (cfg_n_samples==0 || cfg_n_taps==0)
- start in IDLE with cfg_err=0:
  - go to RUN with k=0, j=0
  - cfg_load in the same cycle takes effect first, and start uses the new values and the new cfg_err
- Output sequence: for k = 0..N+T-2, j runs from jmin(k) to jmax(k).
  - jmin(k) = (k >= N) ? k-N+1 : 0
  - jmax(k) = min(k, T-1)
  - a_sample = k-j, a_coef = j
  - first = (j==jmin(k)), last = (j==jmax(k))
- Total pairs per run = N*T. Total last pulses = N+T-1.
- Advance happens on out_valid && out_ready:
  - if j < jmax(k): j <= j+1
  - else if k < N+T-2: k <= k+1 and j <= jmin(k+1)
  - else: go to IDLE and pulse done
- Arithmetic: k-N+1 is computed at ADDR_W+2 bits to avoid wrap. a_sample is always in 0..N-1 and a_coef in 0..T-1, so no wrap-around on the RAM addresses.
- abort: in RUN, go to IDLE with out_valid=0, no done pulse, and k/j cleared. In IDLE it has no effect. abort wins over start and over a simultaneous handshake.
- cfg_load and start while busy are ignored; N and T stay unchanged mid-run.

## Timing
- Start latency: start in cycle t gives out_valid=1 in cycle t+1, with pair (k=0, j=0).
- Pair outputs are registered.
- Throughput: with out_ready held high, one pair per cycle, with no bubble at k boundaries.
- Backpressure: while out_valid && !out_ready, a_sample, a_coef, out_k, first and last hold stable.
- Completion: if the final pair is accepted in cycle t, then in cycle t+1 done=1, out_valid=0 and busy=0. done is 0 again in t+2. A new start is accepted in t+1.
- abort in cycle t: out_valid=0 and busy=0 from t+1.
- cfg_err updates in the cycle after cfg_load.
- Asynchronous reset mid-run immediately forces every output to 0.

## Test plan
- N=4, T=3, out_ready=1:
  - exactly 12 pairs over 12 consecutive cycles, then a done pulse
  - (k, j) order: 0:(0) 1:(0,1) 2:(0,1,2) 3:(0,1,2) 4:(1,2) 5:(2)
  - a_sample = k-j
  - first/last asserted on the end pairs of each k; 6 last pulses in total
- N=1, T=1: one pair (0,0) with first=last=1, then done the next cycle. Run again with N=2^ADDR_W and T=2^COEF_W: pair count = N*T and the last a_sample = N-1.
- N=3, T=5 with out_ready toggling randomly: the captured stream equals the out_ready=1 stream, and outputs stay stable during every stall.
- cfg_load with N=0: cfg_err=1 and start is ignored (busy stays 0). A following cfg_load with N=2, T=2 clears cfg_err and the run yields 4 pairs.
- abort after the 5th handshake of an N=4, T=3 run: out_valid=0 next cycle and no done pulse. A following start restarts at (0,0).
- cfg_load with N=7 and start issued mid-run: both are ignored, and the run completes with the original N*T pairs.
